// File: rtl/gol_pkg.sv
// Shared Game-of-Life types and constants: scanner FSM states, neighbour
// visiting order, default grid size and the Conway B3/S23 rule masks.
package gol_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_WAIT,
        ST_DONE
    } scan_state_t;

    localparam int GRID_W_DEF = 15;
    localparam int GRID_H_DEF = 20;

    localparam logic [8:0] MASK_B3  = 9'b000001000;
    localparam logic [8:0] MASK_S23 = 9'b000001100;

    // Visiting order: centre first, then clockwise starting at north.
    localparam logic [3:0] IDX_C  = 4'd0;
    localparam logic [3:0] IDX_N  = 4'd1;
    localparam logic [3:0] IDX_NE = 4'd2;
    localparam logic [3:0] IDX_E  = 4'd3;
    localparam logic [3:0] IDX_SE = 4'd4;
    localparam logic [3:0] IDX_S  = 4'd5;
    localparam logic [3:0] IDX_SW = 4'd6;
    localparam logic [3:0] IDX_W  = 4'd7;
    localparam logic [3:0] IDX_NW = 4'd8;

    function automatic logic signed [1:0] idx_dx(input logic [3:0] idx);
        case (idx)
            IDX_NE, IDX_E, IDX_SE: return 2'sd1;
            IDX_SW, IDX_W, IDX_NW: return -2'sd1;
            default:               return 2'sd0;
        endcase
    endfunction

    // North is y-1, so the northern row steps negative.
    function automatic logic signed [1:0] idx_dy(input logic [3:0] idx);
        case (idx)
            IDX_N, IDX_NE, IDX_NW: return -2'sd1;
            IDX_SE, IDX_S, IDX_SW: return 2'sd1;
            default:               return 2'sd0;
        endcase
    endfunction

endpackage

// File: rtl/neighbour_scanner_coord_step.sv
// One-axis coordinate stepper: moves a coordinate by -1/0/+1 with either
// toroidal wrap or an off-grid flag at the edges (compare-and-select only).
module coord_step #(
    parameter int W    = 4,
    parameter int MAX  = 15,
    parameter bit WRAP = 1'b1
) (
    input  logic [W-1:0]       i_coord,
    input  logic signed [1:0]  i_dir,
    output logic [W-1:0]       o_coord,
    output logic               o_off_grid
);

    localparam logic [W-1:0] LAST = W'(MAX - 1);

    always_comb begin
        o_coord    = i_coord;
        o_off_grid = 1'b0;
        if (i_dir == 2'sd1) begin
            if (i_coord == LAST) begin
                o_coord    = '0;
                o_off_grid = !WRAP;
            end else begin
                o_coord = i_coord + W'(1);
            end
        end else if (i_dir == -2'sd1) begin
            if (i_coord == '0) begin
                o_coord    = WRAP ? LAST : '0;
                o_off_grid = !WRAP;
            end else begin
                o_coord = i_coord - W'(1);
            end
        end
    end

endmodule

// File: rtl/neighbour_scanner.sv
// Sequential neighbour evaluator: reads a cell and its eight neighbours one per
// cycle from single-port cell RAM, counts live neighbours and applies a B/S rule.
module neighbour_scanner
    import gol_pkg::*;
#(
    parameter int         GRID_W       = GRID_W_DEF,
    parameter int         GRID_H       = GRID_H_DEF,
    parameter int         XW           = $clog2(GRID_W),
    parameter int         YW           = $clog2(GRID_H),
    parameter bit         WRAP         = 1'b1,
    parameter logic [8:0] BIRTH_MASK   = MASK_B3,
    parameter logic [8:0] SURVIVE_MASK = MASK_S23
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_valid,
    output logic          o_ready,
    input  logic [XW-1:0] i_x,
    input  logic [YW-1:0] i_y,
    output logic          o_rd_en,
    output logic [XW-1:0] o_rd_x,
    output logic [YW-1:0] o_rd_y,
    input  logic          i_rd_data,
    output logic          o_valid,
    input  logic          i_ready,
    output logic [3:0]    o_sum,
    output logic          o_alive,
    output logic          o_next,
    output logic          o_err
);

    localparam logic [XW:0] X_LIM = (XW + 1)'(GRID_W);
    localparam logic [YW:0] Y_LIM = (YW + 1)'(GRID_H);

    scan_state_t   r_state;
    scan_state_t   w_state_nxt;
    logic [XW-1:0] r_x;
    logic [YW-1:0] r_y;
    logic [3:0]    r_idx;
    logic [3:0]    r_sum;
    logic          r_alive;
    logic          r_err;
    logic          r_pend_vld;
    logic          r_pend_ctr;

    logic [XW-1:0] w_cx;
    logic [YW-1:0] w_cy;
    logic          w_offx;
    logic          w_offy;
    logic          w_rd_en;
    logic          w_oob;
    logic          w_accept;

    assign w_oob = ({1'b0, i_x} >= X_LIM) || ({1'b0, i_y} >= Y_LIM);

    coord_step #(
        .W    (XW),
        .MAX  (GRID_W),
        .WRAP (WRAP)
    ) u_step_x (
        .i_coord    (r_x),
        .i_dir      (idx_dx(r_idx)),
        .o_coord    (w_cx),
        .o_off_grid (w_offx)
    );

    coord_step #(
        .W    (YW),
        .MAX  (GRID_H),
        .WRAP (WRAP)
    ) u_step_y (
        .i_coord    (r_y),
        .i_dir      (idx_dy(r_idx)),
        .o_coord    (w_cy),
        .o_off_grid (w_offy)
    );

    // Off-grid slots still consume their cycle so latency never varies.
    assign w_rd_en = (r_state == ST_READ) && !w_offx && !w_offy;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        o_ready     = 1'b0;
        o_valid     = 1'b0;
        w_accept    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                o_ready = 1'b1;
                if (i_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = w_oob ? ST_DONE : ST_READ;
                end
            end
            ST_READ: begin
                if (r_idx == IDX_NW) begin
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                o_valid = 1'b1;
                if (i_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_x        <= '0;
            r_y        <= '0;
            r_idx      <= '0;
            r_sum      <= '0;
            r_alive    <= 1'b0;
            r_err      <= 1'b0;
            r_pend_vld <= 1'b0;
            r_pend_ctr <= 1'b0;
        end else begin
            // Tag each issued read so its data, one cycle later, lands in the right place.
            r_pend_vld <= w_rd_en;
            r_pend_ctr <= (r_idx == IDX_C);
            if (r_state == ST_READ) begin
                r_idx <= r_idx + 4'd1;
            end
            if (r_pend_vld) begin
                if (r_pend_ctr) begin
                    r_alive <= i_rd_data;
                end else begin
                    r_sum <= r_sum + {3'b000, i_rd_data};
                end
            end
            if (w_accept) begin
                r_x     <= i_x;
                r_y     <= i_y;
                r_idx   <= '0;
                r_sum   <= '0;
                r_alive <= 1'b0;
                r_err   <= w_oob;
            end
            if ((r_state == ST_DONE) && i_ready) begin
                r_err <= 1'b0;
            end
        end
    end

    assign o_rd_en = w_rd_en;
    assign o_rd_x  = w_rd_en ? w_cx : '0;
    assign o_rd_y  = w_rd_en ? w_cy : '0;
    assign o_sum   = r_sum;
    assign o_alive = r_alive;
    assign o_err   = r_err;
    assign o_next  = ((r_state == ST_DONE) && !r_err)
                   ? (r_alive ? SURVIVE_MASK[r_sum] : BIRTH_MASK[r_sum])
                   : 1'b0;

endmodule
